// File: rtl/lz_token_packer_pkg.sv
// rtl/lz_token_packer_pkg.sv - shared types and constants for the LZ token packer
package lz_pkg;

    // One encoder token; packed so {offset, match_len} forms the header byte
    typedef struct packed {
        logic [3:0] offset;
        logic [3:0] match_len;
        logic [7:0] char_nxt;
    } lz_token_t;

    // Serializer: IDLE waits for a token, HDR sends {offset,len}, CHR sends the char
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_CHR  = 2'd2
    } ser_state_t;

    localparam logic [7:0] LZ_END_CHAR = 8'h24;

endpackage

// File: rtl/lz_token_packer_if.sv
// rtl/lz_token_packer_if.sv - valid/ready byte stream carrying serialized tokens
interface lz_byte_if;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;

    modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
    modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);
endinterface

// File: rtl/lz_token_packer_fifo.sv
// rtl/lz_token_packer_fifo.sv - synchronous token FIFO with wrap-bit pointers
module lz_token_fifo
    import lz_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  lz_token_t push_data,
    input  logic      pop,
    output lz_token_t pop_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    lz_token_t   mem [DEPTH];
    logic        do_push, do_pop;

    // Equal pointers mean empty; same index with differing wrap bit means full
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    // Advance each pointer by one on an accepted operation; wraps naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/lz_token_packer.sv
// rtl/lz_token_packer.sv - buffers encoder tokens and serializes them as two-byte frames
module lz_token_packer
    import lz_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] END_CHAR   = LZ_END_CHAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_encode,
    input  logic [3:0] in_offset,
    input  logic [3:0] in_match_len,
    input  logic [7:0] in_char,
    lz_byte_if.master  byte_if,
    output logic       frame_done,
    output logic [7:0] tok_count,
    output logic       overflow
);
    ser_state_t state_q, state_d;
    lz_token_t  hold_q, hold_d;
    lz_token_t  fifo_dout, in_tok;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic       tok_qual, tok_push, frame_end;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_last_q, byte_last_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] tok_count_q, tok_count_d;
    logic       overflow_q, overflow_d;

    assign in_tok    = '{offset: in_offset, match_len: in_match_len, char_nxt: in_char};
    assign tok_qual  = in_valid && in_encode;
    assign tok_push  = tok_qual && !fifo_full;
    assign frame_end = (state_q == ST_CHR) && byte_if.byte_ready && byte_last_q;

    lz_token_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (tok_push),
        .push_data (in_tok),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Serializer next state; byte outputs are precomputed from the next state so they leave flops
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_dout;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (byte_if.byte_ready) begin
                    state_d = ST_CHR;
                end
            end
            ST_CHR: begin
                if (byte_if.byte_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_dout;
                        state_d  = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        byte_valid_d = 1'b0;
        byte_data_d  = 8'h00;
        byte_last_d  = 1'b0;
        case (state_d)
            ST_HDR: begin
                byte_valid_d = 1'b1;
                byte_data_d  = {hold_d.offset, hold_d.match_len};
            end
            ST_CHR: begin
                byte_valid_d = 1'b1;
                byte_data_d  = hold_d.char_nxt;
                byte_last_d  = (hold_d.char_nxt == END_CHAR);
            end
            default: ;
        endcase
    end

    // Frame bookkeeping: count accepted tokens, restart at frame end, latch drops
    always_comb begin
        frame_done_d = frame_end;
        tok_count_d  = tok_count_q;
        overflow_d   = overflow_q || (tok_qual && fifo_full);
        if (frame_end) begin
            tok_count_d = tok_push ? 8'd1 : 8'd0;
        end else if (tok_push && (tok_count_q != 8'hFF)) begin
            tok_count_d = tok_count_q + 8'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
            tok_count_q  <= 8'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_last_q  <= byte_last_d;
            frame_done_q <= frame_done_d;
            tok_count_q  <= tok_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign byte_if.byte_valid = byte_valid_q;
    assign byte_if.byte_data  = byte_data_q;
    assign byte_if.byte_last  = byte_last_q;
    assign frame_done         = frame_done_q;
    assign tok_count          = tok_count_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_lz_token_packer.sv
// tb/tb_lz_token_packer.sv - self-checking bench for lz_token_packer
module tb_lz_token_packer;
    import lz_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [7:0] ENDC  = 8'h24;

    logic       clk;
    logic       reset;
    logic       in_valid, in_encode;
    logic [3:0] in_offset, in_match_len;
    logic [7:0] in_char;
    logic       frame_done, overflow;
    logic [7:0] tok_count;

    lz_byte_if bif ();

    lz_token_packer #(.FIFO_DEPTH(DEPTH), .END_CHAR(ENDC)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_encode    (in_encode),
        .in_offset    (in_offset),
        .in_match_len (in_match_len),
        .in_char      (in_char),
        .byte_if      (bif),
        .frame_done   (frame_done),
        .tok_count    (tok_count),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: expected byte stream, frame token count, flags
    logic [7:0] exp_q[$];
    bit         expl_q[$];
    logic [7:0] got_d[$];
    bit         got_l[$];
    int         m_cnt;
    bit         m_ovf, m_fd;
    int         fd_seen;
    bit         prev_v, prev_r, prev_l;
    logic [7:0] prev_d;

    typedef struct {
        logic [3:0] off;
        logic [3:0] len;
        logic [7:0] ch;
        logic [7:0] e_hdr;
        logic [7:0] e_chr;
        bit         e_last;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic lz_token_t mk(input logic [3:0] o, input logic [3:0] l, input logic [7:0] c);
        lz_token_t t;
        t.offset = o; t.match_len = l; t.char_nxt = c;
        return t;
    endfunction

    task automatic model_clear();
        exp_q.delete(); expl_q.delete();
        m_cnt = 0; m_ovf = 0; m_fd = 0;
        prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 8'h00;
    endtask

    // One clock cycle: drive inputs, score any handshake, advance the model, check after the edge
    task automatic cycle(input bit tv, input bit enc, input lz_token_t t, input bit rdy, input bit acc);
        bit hs, hs_last, qual;
        in_valid = tv; in_encode = enc;
        in_offset = t.offset; in_match_len = t.match_len; in_char = t.char_nxt;
        bif.byte_ready = rdy;
        if (prev_v && !prev_r) begin
            chk("stall_valid", {31'd0, bif.byte_valid}, 32'd1);
            chk("stall_data", {23'd0, bif.byte_last, bif.byte_data}, {23'd0, prev_l, prev_d});
        end
        hs = bif.byte_valid && rdy;
        hs_last = 0;
        if (hs) begin
            got_d.push_back(bif.byte_data);
            got_l.push_back(bif.byte_last);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_byte got=%0h exp=none", bif.byte_data);
            end else begin
                logic [7:0] e;
                bit el;
                e = exp_q.pop_front();
                el = expl_q.pop_front();
                chk("byte_data", {24'd0, bif.byte_data}, {24'd0, e});
                chk("byte_last", {31'd0, bif.byte_last}, {31'd0, el});
                hs_last = el;
            end
        end
        qual = tv && enc;
        if (qual && acc) begin
            exp_q.push_back({t.offset, t.match_len}); expl_q.push_back(1'b0);
            exp_q.push_back(t.char_nxt);              expl_q.push_back(t.char_nxt == ENDC);
        end
        if (qual && !acc) m_ovf = 1;
        if (hs_last) m_cnt = (qual && acc) ? 1 : 0;
        else if (qual && acc && m_cnt < 255) m_cnt++;
        prev_v = bif.byte_valid; prev_r = rdy; prev_d = bif.byte_data; prev_l = bif.byte_last;
        @(posedge clk);
        #1;
        m_fd = hs_last;
        if (frame_done) fd_seen++;
        chk("tok_count", {24'd0, tok_count}, m_cnt);
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, mk(4'h0, 4'h0, 8'h00), rdy, 1'b1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || bif.byte_valid) && n < max) begin
            idle(1'b1);
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
        chk("drain_idle", {31'd0, bif.byte_valid}, 32'd0);
    endtask

    task automatic tok3(input lz_token_t t);
        cycle(1'b1, 1'b1, t, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'h0, 4'h0, 8'h41, 8'h00, 8'h41, 1'b0};
        tbl[1] = '{4'h0, 4'h1, 8'h61, 8'h01, 8'h61, 1'b0};
        tbl[2] = '{4'hF, 4'hF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[3] = '{4'h1, 4'h0, 8'h00, 8'h10, 8'h00, 1'b0};
        tbl[4] = '{4'hA, 4'h5, 8'h25, 8'hA5, 8'h25, 1'b0};
        tbl[5] = '{4'h3, 4'h2, 8'h24, 8'h32, 8'h24, 1'b1};

        in_valid = 0; in_encode = 0; in_offset = 0; in_match_len = 0; in_char = 0;
        bif.byte_ready = 0;
        reset = 0;
        model_clear();
        fd_seen = 0;
        #1 reset = 1;
        #2;
        chk("rst_valid", {31'd0, bif.byte_valid}, 0);
        chk("rst_data", {24'd0, bif.byte_data}, 0);
        chk("rst_last", {31'd0, bif.byte_last}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_tok_count", {24'd0, tok_count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Single token latency: valid rises after the second edge following the strobe
        cycle(1'b1, 1'b1, mk(4'h0, 4'h0, 8'h41), 1'b1, 1'b1);
        chk("lat_e0_valid", {31'd0, bif.byte_valid}, 0);
        idle(1'b1);
        chk("lat_e1_valid", {31'd0, bif.byte_valid}, 1);
        chk("lat_e1_data", {24'd0, bif.byte_data}, 32'h00);
        drain(20);

        // Table of isolated tokens
        for (int i = 0; i < 6; i++) begin
            got_d.delete(); got_l.delete();
            cycle(1'b1, 1'b1, mk(tbl[i].off, tbl[i].len, tbl[i].ch), 1'b1, 1'b1);
            drain(20);
            chk($sformatf("tbl%0d_nbytes", i), got_d.size(), 2);
            if (got_d.size() == 2) begin
                chk($sformatf("tbl%0d_hdr", i), {24'd0, got_d[0]}, {24'd0, tbl[i].e_hdr});
                chk($sformatf("tbl%0d_chr", i), {24'd0, got_d[1]}, {24'd0, tbl[i].e_chr});
                chk($sformatf("tbl%0d_last", i), {31'd0, got_l[1]}, {31'd0, tbl[i].e_last});
                chk($sformatf("tbl%0d_hdr_last", i), {31'd0, got_l[0]}, 0);
            end
        end

        // Full frame at 3-cycle spacing
        begin
            logic [7:0] ff_exp[6];
            ff_exp = '{8'h00, 8'h61, 8'h01, 8'h62, 8'h32, 8'h24};
            got_d.delete(); got_l.delete();
            fd_seen = 0;
            tok3(mk(4'h0, 4'h0, 8'h61));
            tok3(mk(4'h0, 4'h1, 8'h62));
            chk("ff_count_2", {24'd0, tok_count}, 2);
            tok3(mk(4'h3, 4'h2, 8'h24));
            drain(20);
            chk("ff_nbytes", got_d.size(), 6);
            for (int i = 0; i < 6 && i < got_d.size(); i++) begin
                chk($sformatf("ff_byte%0d", i), {24'd0, got_d[i]}, {24'd0, ff_exp[i]});
                chk($sformatf("ff_last%0d", i), {31'd0, got_l[i]}, (i == 5) ? 1 : 0);
            end
            chk("ff_fd_pulses", fd_seen, 1);
            chk("ff_count_after", {24'd0, tok_count}, 0);
        end

        // Frame boundary: next frame's first token coincides with last-byte handshake
        begin
            int n = 0;
            tok3(mk(4'h1, 4'h1, 8'h7A));
            cycle(1'b1, 1'b1, mk(4'h2, 4'h2, 8'h24), 1'b1, 1'b1);
            while (!(bif.byte_valid && bif.byte_last) && n < 30) begin
                idle(1'b1);
                n++;
            end
            chk("fb_last_seen", (n < 30) ? 1 : 0, 1);
            cycle(1'b1, 1'b1, mk(4'h4, 4'h3, 8'h51), 1'b1, 1'b1);
            chk("fb_frame_done", {31'd0, frame_done}, 1);
            chk("fb_tok_count", {24'd0, tok_count}, 1);
            drain(20);
        end

        // Decoder-phase traffic is ignored
        begin
            logic [7:0] cnt0;
            cnt0 = tok_count;
            got_d.delete(); got_l.delete();
            for (int i = 0; i < 10; i++)
                cycle(1'b1, 1'b0, mk(4'($urandom), 4'($urandom), 8'($urandom)), 1'b1, 1'b1);
            chk("dec_nbytes", got_d.size(), 0);
            chk("dec_tok_count", {24'd0, tok_count}, {24'd0, cnt0});
        end

        // Randomized traffic with backpressure, issued only while the FIFO surely has room
        begin
            int issued = 0, gap = 0, cyc = 0;
            while (issued < 60 && cyc < 3000) begin
                bit rdy;
                int outstanding;
                rdy = ($urandom_range(0, 3) != 0);
                outstanding = (exp_q.size() + 1) / 2;
                if (gap == 0 && outstanding < DEPTH) begin
                    logic [7:0] c;
                    c = ($urandom_range(0, 5) == 0) ? ENDC : 8'($urandom);
                    cycle(1'b1, 1'b1, mk(4'($urandom), 4'($urandom), c), rdy, 1'b1);
                    issued++;
                    gap = $urandom_range(2, 5);
                end else begin
                    bit tv;
                    tv = $urandom_range(0, 1) == 1;
                    cycle(tv, tv ? 1'b0 : 1'($urandom), mk(4'($urandom), 4'($urandom), 8'($urandom)), rdy, 1'b1);
                    if (gap > 0) gap--;
                end
                cyc++;
            end
            chk("rnd_issued", issued, 60);
            drain(100);
        end

        // Backpressure: DEPTH+2 tokens against a stalled sink; one in the serializer, DEPTH queued, last dropped
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0)
                cycle(1'b1, 1'b1, mk(4'(i / 2), 4'hC, 8'h30 + 8'(i / 2)), 1'b0, (i / 2) < DEPTH + 1);
            else
                idle(1'b0);
        end
        chk("bp_overflow", {31'd0, overflow}, 1);
        chk("bp_no_bytes_in_stall", got_d.size(), 0);
        drain(60);
        chk("bp_nbytes", got_d.size(), 2 * (DEPTH + 1));
        for (int k = 0; k < DEPTH + 1 && 2 * k + 1 < got_d.size(); k++) begin
            chk($sformatf("bp_hdr%0d", k), {24'd0, got_d[2*k]}, {24'd0, 4'(k), 4'hC});
            chk($sformatf("bp_chr%0d", k), {24'd0, got_d[2*k+1]}, 32'h30 + k);
        end

        // Reset while in CHR with three tokens queued behind it
        cycle(1'b1, 1'b1, mk(4'h5, 4'h5, 8'h55), 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, mk(4'h6, 4'(k), 8'h60 + 8'(k)), 1'b0, 1'b1);
            if (k < 2) begin idle(1'b0); idle(1'b0); end
        end
        chk("mr_in_chr_valid", {31'd0, bif.byte_valid}, 1);
        chk("mr_in_chr_data", {24'd0, bif.byte_data}, 32'h55);
        in_valid = 0; in_encode = 0;
        #2 reset = 1;
        #1;
        chk("mr_valid", {31'd0, bif.byte_valid}, 0);
        chk("mr_data", {24'd0, bif.byte_data}, 0);
        chk("mr_last", {31'd0, bif.byte_last}, 0);
        chk("mr_frame_done", {31'd0, frame_done}, 0);
        chk("mr_tok_count", {24'd0, tok_count}, 0);
        chk("mr_overflow", {31'd0, overflow}, 0);
        model_clear();
        @(posedge clk); #1;
        reset = 0;
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 12; i++) idle(1'b1);
        chk("mr_no_stale_bytes", got_d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
